data_out_arbiter: RTL and testbench
===================================

Name: data_out_arbiter

Overview:
- Shares the single DATA_W-bit registered output o_a between NUM_REQ requesters.
- Each requester uses a valid/ready handshake. Arbitration is round-robin and locked per burst: a granted requester keeps the output until its beat flagged last transfers.
- Sits in front of the top-level o_a port and replaces the constant-driven data field with a sequenced datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of each data beat and of o_a.
- IDX_W, $clog2(NUM_REQ), width of the grant index (derived; do not override).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  NUM_REQ  per-requester beat valid.
- i_req_last  in  NUM_REQ  per-requester last-beat-of-burst flag, qualified by valid.
- i_req_data  in  NUM_REQ*DATA_W  packed beats; requester k uses bits [k*DATA_W +: DATA_W].
- o_req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- o_a  out  DATA_W  registered output data.
- o_a_valid  out  1  o_a holds an unconsumed beat.
- o_a_last  out  1  beat in o_a is last of its burst.
- o_a_src  out  IDX_W  index of the requester that supplied o_a.
- i_a_ready  in  1  downstream accepts o_a this cycle.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - o_a=0, o_a_valid=0, o_a_last=0, o_a_src=0.
  - State=ARB, rr pointer=0, lock index=0.
  - o_req_ready=0 while i_rst_n=0.
- Load enable: load = !o_a_valid | i_a_ready. The output register takes a new beat only when load=1. This gives full throughput, one beat per cycle, with no bubble.
- Accept: a beat from requester k transfers when i_req_valid[k] & o_req_ready[k]. Next cycle o_a=data_k, o_a_valid=1, o_a_last=i_req_last[k], o_a_src=k. Latency is 1 cycle from accept to o_a.
- Drain with no new accept: when load=1 and no requester transfers, o_a_valid clears next cycle; o_a, o_a_src and o_a_last keep their old values.
- o_req_ready is combinational from state, valid, pointer and load. It never depends on i_req_data.
- State ARB:
  - If load=1, grant the first requester with valid set, searching from rr pointer upward modulo NUM_REQ.
  - o_req_ready[g]=1 for that requester only.
  - On transfer with last=1: stay in ARB, pointer=(g+1) mod NUM_REQ.
  - On transfer with last=0: go to LOCKED, lock index=g.
  - No valid requesters, or load=0: o_req_ready=0 and the pointer is unchanged.
- State LOCKED:
  - o_req_ready[lock]=load & i_req_valid[lock]; all other bits are 0.
  - Gaps (valid low) keep the lock; other requesters stall indefinitely.
  - Transfer with last=1: go to ARB, pointer=(lock+1) mod NUM_REQ.
- Single-beat bursts (last=1 on the first beat) never enter LOCKED.
- Pointer wrap: NUM_REQ-1 advances to 0.
- Downstream stall (o_a_valid=1, i_a_ready=0):
  - o_a, o_a_valid, o_a_last and o_a_src hold stable; o_req_ready=0.
  - State and pointer are unchanged.
- Same-cycle drain and load: the new beat replaces the old one with no gap, and o_a_valid stays 1.
- Reset mid-burst: aborts the lock, clears o_a_valid, pointer returns to 0. No partial-burst state survives reset.
- Requesters must hold data/last stable while valid is high without ready. The block does not check this.

Optional Feature:
- Macro: DATA_OUT_ARB_BEAT_CNT_EN.
- Defined: adds output o_beat_cnt [15:0].
  - Increments by 1 on every downstream transfer (o_a_valid & i_a_ready) and wraps 0xFFFF->0.
  - Reset value is 0.
  - A drain and a load in the same cycle count as 1.
- Undefined: the port and counter are absent, and the remaining behaviour is identical.

Test Plan:
- Reset/idle:
  - Assert i_rst_n=0 mid-run with o_a_valid=1 -> o_a=0x00, o_a_valid=0 and o_req_ready=0 immediately, without waiting for a clock edge.
  - After release with no valids -> outputs stay 0.
- Round-robin:
  - Requesters 0..3 all valid, every beat last=1, i_a_ready=1 -> o_a_src sequence 0,1,2,3,0.
  - o_a equals each requester's data, e.g. 0x10, 0x21, 0x32, 0x43.
  - o_a_valid stays high every cycle with no bubbles.
- Burst lock:
  - Requester 1 sends 3 beats 0xA0, 0xA1, 0xA2 (last on the third) while requester 2 is valid with 0xB0 -> o_a = 0xA0, 0xA1, 0xA2, then 0xB0.
  - o_req_ready[2]=0 until the cycle after 0xA2 is accepted.
- Lock with gap:
  - Requester 3 drops valid for 2 cycles mid-burst while requester 0 is valid -> no grant to 0 until requester 3's last beat transfers.
  - Pointer then wraps to 0.
- Backpressure:
  - Hold i_a_ready=0 for 4 cycles with o_a=0x5C -> o_a, o_a_src and o_a_last stay stable; all o_req_ready=0.
  - Raise i_a_ready -> the next beat loads in the same cycle and o_a_valid does not drop.
- Beat counter (DATA_OUT_ARB_BEAT_CNT_EN defined):
  - Preload via 65537 transfers -> o_beat_cnt reads 0x0001 after wrapping.
  - Build without the macro -> port absent and the other scenarios still pass.

Source files
------------

// File: rtl/data_out_arbiter_if.sv
// rtl/data_out_arbiter_if.sv - requester/downstream bus of the data_out_arbiter
interface data_out_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ-1:0]        i_req_last;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic [DATA_W-1:0]         o_a;
  logic                      o_a_valid;
  logic                      o_a_last;
  logic [IDX_W-1:0]          o_a_src;
  logic                      i_a_ready;

  // master: the arbiter itself; slave: requesters plus downstream sink
  modport master (
    input  i_req_valid, i_req_last, i_req_data, i_a_ready,
    output o_req_ready, o_a, o_a_valid, o_a_last, o_a_src
  );

  modport slave (
    output i_req_valid, i_req_last, i_req_data, i_a_ready,
    input  o_req_ready, o_a, o_a_valid, o_a_last, o_a_src
  );
endinterface

// File: rtl/data_out_arbiter.sv
// rtl/data_out_arbiter.sv - burst-locked round-robin arbiter onto registered o_a
// Optional beat counter output o_beat_cnt enabled by DATA_OUT_ARB_BEAT_CNT_EN.
module data_out_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  data_out_arbiter_if.master   bus
`ifdef DATA_OUT_ARB_BEAT_CNT_EN
  ,
  output logic [15:0]          o_beat_cnt
`endif
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    lock_q, lock_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic                a_valid_q, a_valid_d;
  logic                a_last_q, a_last_d;
  logic [IDX_W-1:0]    a_src_q, a_src_d;

  logic                load;
  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W:0]      cand;
  logic [NUM_REQ-1:0]  ready;
  logic [IDX_W-1:0]    sel;
  logic                xfer;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;
  logic [IDX_W-1:0]    sel_next;

  // First valid requester at or after the round-robin pointer, modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_found && bus.i_req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    load     = !a_valid_q | bus.i_a_ready;
    sel      = (state_q == LOCKED) ? lock_q : grant_idx;
    ready    = '0;
    if (i_rst_n && load) begin
      if (state_q == LOCKED) begin
        ready[lock_q] = bus.i_req_valid[lock_q];
      end else if (grant_found) begin
        ready[grant_idx] = 1'b1;
      end
    end
    xfer     = |ready;
    sel_last = bus.i_req_last[sel];
    sel_data = bus.i_req_data[int'(sel)*DATA_W +: DATA_W];
    sel_next = (sel == IDX_W'(NUM_REQ-1)) ? '0 : sel + IDX_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    a_d       = a_q;
    a_valid_d = a_valid_q;
    a_last_d  = a_last_q;
    a_src_d   = a_src_q;
    if (xfer) begin
      a_d       = sel_data;
      a_valid_d = 1'b1;
      a_last_d  = sel_last;
      a_src_d   = sel;
      if (sel_last) begin
        state_d = ARB;
        rr_d    = sel_next;
      end else if (state_q == ARB) begin
        state_d = LOCKED;
        lock_d  = sel;
      end
    end else if (load) begin
      // Drain only: payload fields keep their last values.
      a_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ARB;
      rr_q      <= '0;
      lock_q    <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_src_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      a_last_q  <= a_last_d;
      a_src_q   <= a_src_d;
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_a         = a_q;
  assign bus.o_a_valid   = a_valid_q;
  assign bus.o_a_last    = a_last_q;
  assign bus.o_a_src     = a_src_q;

`ifdef DATA_OUT_ARB_BEAT_CNT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (a_valid_q && bus.i_a_ready) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign o_beat_cnt = beat_cnt_q;
`endif
endmodule

// File: tb/tb_data_out_arbiter.sv
// tb/tb_data_out_arbiter.sv - randomized and directed bench for data_out_arbiter
module tb_data_out_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [NUM_REQ-1:0] rdy_seen;

  // Reference state: pointer, lock owner (-1 when arbitrating), output register.
  int          m_ptr, m_lock, m_as;
  logic [7:0]  m_a;
  logic        m_av, m_al;
  logic [15:0] m_cnt;

  data_out_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

`ifdef DATA_OUT_ARB_BEAT_CNT_EN
  logic [15:0] beat_cnt;
  data_out_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_beat_cnt(beat_cnt));
`else
  data_out_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = -1; m_as = 0; m_a = '0; m_av = 0; m_al = 0; m_cnt = '0;
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    bus.i_req_valid[k] = v;
    bus.i_req_data[k*DATA_W +: DATA_W] = d;
    bus.i_req_last[k] = l;
  endtask

  task automatic clear_reqs();
    bus.i_req_valid = '0;
    bus.i_req_last  = '0;
    bus.i_req_data  = '0;
  endtask

  // One clock: check ready against the model, advance the model, check registers.
  task automatic step();
    logic [NUM_REQ-1:0] er;
    int g;
    bit ld;
    #1;
    er = '0;
    g  = -1;
    ld = !m_av || bus.i_a_ready;
    if (ld) begin
      if (m_lock >= 0) begin
        if (bus.i_req_valid[m_lock]) g = m_lock;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          int k = (m_ptr + i) % NUM_REQ;
          if (g < 0 && bus.i_req_valid[k]) g = k;
        end
      end
    end
    if (g >= 0) er[g] = 1'b1;
    rdy_seen = bus.o_req_ready;
    check("ready", bus.o_req_ready, er);
    if (m_av && bus.i_a_ready) m_cnt = m_cnt + 16'd1;
    if (g >= 0) begin
      m_a  = bus.i_req_data[g*DATA_W +: DATA_W];
      m_av = 1'b1;
      m_al = bus.i_req_last[g];
      m_as = g;
      if (m_al) begin
        m_lock = -1;
        m_ptr  = (g + 1) % NUM_REQ;
      end else begin
        m_lock = g;
      end
    end else if (ld) begin
      m_av = 1'b0;
    end
    @(posedge clk);
    #1;
    check("o_a", bus.o_a, m_a);
    check("o_a_valid", bus.o_a_valid, m_av);
    check("o_a_last", bus.o_a_last, m_al);
    check("o_a_src", bus.o_a_src, m_as);
`ifdef DATA_OUT_ARB_BEAT_CNT_EN
    check("beat_cnt", beat_cnt, m_cnt);
`endif
  endtask

  logic [7:0] rr_data [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

  initial begin
    rst_n = 1'b0;
    bus.i_a_ready = 1'b0;
    clear_reqs();
    bus.i_req_valid = '1;
    model_reset();
    #12;
    check("rst_ready", bus.o_req_ready, 0);
    check("rst_o_a", bus.o_a, 0);
    check("rst_valid", bus.o_a_valid, 0);
    check("rst_src", bus.o_a_src, 0);
    clear_reqs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    bus.i_a_ready = 1'b1;
    repeat (2) step();
    check("idle_o_a", bus.o_a, 0);
    check("idle_valid", bus.o_a_valid, 0);

    // Round robin, single-beat bursts from all requesters.
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b1, rr_data[k], 1'b1);
    for (int n = 0; n < 5; n++) begin
      step();
      check("rr_src", bus.o_a_src, n % NUM_REQ);
      check("rr_data", bus.o_a, rr_data[n]);
      check("rr_valid", bus.o_a_valid, 1);
    end
    clear_reqs();
    step();

    // Burst lock: requester 1 holds the output over requester 2.
    for (int b = 0; b < 3; b++) begin
      set_req(1, 1'b1, 8'hA0 + 8'(b), b == 2);
      set_req(2, 1'b1, 8'hB0, 1'b1);
      step();
      check("lock_rdy", rdy_seen, 4'b0010);
      check("lock_data", bus.o_a, 8'hA0 + 8'(b));
    end
    set_req(1, 1'b0, 8'h00, 1'b0);
    step();
    check("lock_rdy2", rdy_seen, 4'b0100);
    check("lock_b0", bus.o_a, 8'hB0);
    clear_reqs();

    // Lock with a 2-cycle gap; requester 0 must wait, then pointer wraps.
    set_req(3, 1'b1, 8'hC0, 1'b0);
    set_req(0, 1'b1, 8'hD0, 1'b1);
    step();
    check("gap_first", rdy_seen, 4'b1000);
    set_req(3, 1'b0, 8'h00, 1'b0);
    repeat (2) begin
      step();
      check("gap_stall", rdy_seen, 0);
    end
    set_req(3, 1'b1, 8'hC1, 1'b1);
    step();
    check("gap_last", bus.o_a, 8'hC1);
    set_req(3, 1'b0, 8'h00, 1'b0);
    step();
    check("gap_wrap", rdy_seen, 4'b0001);
    check("gap_d0", bus.o_a, 8'hD0);
    clear_reqs();

    // Backpressure with 0x5C held, then same-cycle drain and load.
    set_req(2, 1'b1, 8'h5C, 1'b1);
    step();
    check("bp_load", bus.o_a, 8'h5C);
    set_req(2, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b1, 8'h6D, 1'b1);
    bus.i_a_ready = 1'b0;
    repeat (4) begin
      step();
      check("bp_rdy", rdy_seen, 0);
      check("bp_hold", bus.o_a, 8'h5C);
      check("bp_src", bus.o_a_src, 2);
    end
    bus.i_a_ready = 1'b1;
    step();
    check("bp_next", bus.o_a, 8'h6D);
    check("bp_nogap", bus.o_a_valid, 1);
    clear_reqs();
    bus.i_a_ready = 1'b0;

    // Asynchronous reset while o_a_valid is high.
    bus.i_req_valid = '1;
    rst_n = 1'b0;
    #1;
    check("arst_o_a", bus.o_a, 0);
    check("arst_valid", bus.o_a_valid, 0);
    check("arst_ready", bus.o_req_ready, 0);
    model_reset();
    clear_reqs();
    rst_n = 1'b1;
    bus.i_a_ready = 1'b1;
    step();

    // Randomized traffic honouring the hold-while-stalled rule.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!(bus.i_req_valid[k] && !rdy_seen[k])) begin
          set_req(k, $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
        end
      end
      bus.i_a_ready = $urandom_range(0, 3) != 0;
      step();
    end

`ifdef DATA_OUT_ARB_BEAT_CNT_EN
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    bus.i_a_ready = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b1, 8'(k), 1'b1);
    repeat (65538) step();
    check("cnt_wrap", beat_cnt, 16'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
